// File: rtl/syn_fifo_if.sv
// Handshake bundle for syn_fifo.
// The master side (producer/consumer) drives the write and read requests.
// The slave side (the FIFO) returns read data and the full/empty status.
interface syn_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
    input  rd_data,
    input  fifo_full,
    input  fifo_empty
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data,
    output fifo_full,
    output fifo_empty
  );

endinterface

// File: rtl/syn_fifo.sv
// Synchronous single-clock FIFO with a registered read port.
// Storage is a DEPTH x DATA_WIDTH register array addressed by pointers that
// carry one extra wrap bit, so full and empty can be told apart.
// DEPTH must be a power of two and at least 2.
// Optional macro SYN_FIFO_STATUS_EN adds fifo_count, overflow and underflow.
module syn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  syn_fifo_if.slave         bus
`ifdef SYN_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              underflow
`endif
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]       r_wptr;
  logic [ADDR_W:0]       r_rptr;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

  // Flags come straight from the pointers so they track each edge's update
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                       (r_wptr[ADDR_W] != r_rptr[ADDR_W]);
  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_rd_accept = bus.rd_en && !w_empty;

  assign bus.fifo_full  = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.rd_data    = r_rd_data;

  // Storage array; deliberately has no reset, only accepted writes land here
  always_ff @(posedge clk) begin
    if (rstn && w_wr_accept) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  // Pointer and read-data registers; reset empties the FIFO and clears rd_data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_data <= r_mem[r_rptr[ADDR_W-1:0]];
        r_rptr    <= r_rptr + 1'b1;
      end
    end
  end

`ifdef SYN_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  assign fifo_count = r_wptr - r_rptr;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

  // One-cycle error pulses for a write into a full or a read from an empty FIFO
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// Self-checking bench for syn_fifo (DATA_WIDTH=8, DEPTH=8).
// A vector table covers reset and basic ordering; hand-written sequences
// cover full, wrap-around, simultaneous access and mid-operation reset.
// Status outputs are checked when SYN_FIFO_STATUS_EN is defined.
module tb_syn_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  syn_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SYN_FIFO_STATUS_EN
  logic [3:0] fifo_count;
  logic       overflow;
  logic       underflow;
`endif

  syn_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus)
`ifdef SYN_FIFO_STATUS_EN
    ,
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  typedef struct {
    string      name;
    logic       rstn;
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic [7:0] expRd;
    logic       expFull;
    logic       expEmpty;
  } vec_t;

  vec_t vecs [11];
  int   checks = 0;
  int   passes = 0;

  // Compare one value and count the result
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare the three always-present outputs
  task automatic checkOutput(input string name, input logic [7:0] expRd,
                             input logic expFull, input logic expEmpty);
    checkVal({name, "_rd_data"}, 32'(bus.rd_data), 32'(expRd));
    checkVal({name, "_full"}, 32'(bus.fifo_full), 32'(expFull));
    checkVal({name, "_empty"}, 32'(bus.fifo_empty), 32'(expEmpty));
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it
  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d, input logic rd);
    @(negedge clk);
    rstn        = r;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input string n, input logic r, input logic w,
                                 input logic [7:0] d, input logic rd, input logic [7:0] er,
                                 input logic ef, input logic ee);
    vec_t v;
    v.name = n; v.rstn = r; v.wr = w; v.data = d; v.rd = rd;
    v.expRd = er; v.expFull = ef; v.expEmpty = ee;
    return v;
  endfunction

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    //                 name         rstn wr  data   rd  expRd  full empty
    vecs[0]  = mkVec("reset",       0,   0,  8'h00, 0,  8'h00, 0,   1);
    vecs[1]  = mkVec("rd_empty",    1,   0,  8'h00, 1,  8'h00, 0,   1);
    vecs[2]  = mkVec("wr_11",       1,   1,  8'h11, 0,  8'h00, 0,   0);
    vecs[3]  = mkVec("wr_22",       1,   1,  8'h22, 0,  8'h00, 0,   0);
    vecs[4]  = mkVec("wr_33",       1,   1,  8'h33, 0,  8'h00, 0,   0);
    vecs[5]  = mkVec("rd_11",       1,   0,  8'h00, 1,  8'h11, 0,   0);
    vecs[6]  = mkVec("rd_22",       1,   0,  8'h00, 1,  8'h22, 0,   0);
    vecs[7]  = mkVec("rd_33",       1,   0,  8'h00, 1,  8'h33, 0,   1);
    vecs[8]  = mkVec("rd_hold",     1,   0,  8'h00, 1,  8'h33, 0,   1);
    vecs[9]  = mkVec("wr_rd_empty", 1,   1,  8'h44, 1,  8'h33, 0,   0);
    vecs[10] = mkVec("rd_44",       1,   0,  8'h00, 1,  8'h44, 0,   1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].wr, vecs[i].data, vecs[i].rd);
      checkOutput(vecs[i].name, vecs[i].expRd, vecs[i].expFull, vecs[i].expEmpty);
`ifdef SYN_FIFO_STATUS_EN
      if (i == 0) begin
        checkVal("reset_count", 32'(fifo_count), 0);
        checkVal("reset_overflow", 32'(overflow), 0);
        checkVal("reset_underflow", 32'(underflow), 0);
      end
`endif
    end

    // Fill to full, then a write into the full FIFO must be dropped
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 1, 8'(i), 0);
      checkVal("fill_full", 32'(bus.fifo_full), (i == DEPTH - 1) ? 1 : 0);
    end
`ifdef SYN_FIFO_STATUS_EN
    checkVal("fill_count", 32'(fifo_count), 8);
`endif
    applyStimulus(1, 1, 8'hFF, 0);
    checkVal("ovf_full", 32'(bus.fifo_full), 1);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("ovf_pulse", 32'(overflow), 1);
    checkVal("ovf_count", 32'(fifo_count), 8);
`endif
    applyStimulus(1, 0, 8'h00, 0);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("ovf_drop", 32'(overflow), 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 8'h00, 1);
      checkOutput("drain", 8'(i), 0, (i == DEPTH - 1) ? 1'b1 : 1'b0);
    end
    applyStimulus(1, 0, 8'h00, 1);
    checkVal("unf_hold", 32'(bus.rd_data), 32'h07);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("unf_pulse", 32'(underflow), 1);
`endif
    applyStimulus(1, 0, 8'h00, 0);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("unf_drop", 32'(underflow), 0);
`endif

    // Wrap-around: write 5, read 5, write 6, read 6 (pointers cross 2*DEPTH)
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 8'(8'hA0 + i), 0);
`ifdef SYN_FIFO_STATUS_EN
      checkVal("wrap_count_a", 32'(fifo_count), i + 1);
`endif
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 8'h00, 1);
      checkOutput("wrap_rd_a", 8'(8'hA0 + i), 0, (i == 4) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 8'(8'hB0 + i), 0);
      checkVal("wrap_empty_b", 32'(bus.fifo_empty), 0);
`ifdef SYN_FIFO_STATUS_EN
      checkVal("wrap_count_b", 32'(fifo_count), i + 1);
`endif
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 8'h00, 1);
      checkOutput("wrap_rd_b", 8'(8'hB0 + i), 0, (i == 5) ? 1'b1 : 1'b0);
    end

    // Simultaneous read and write with 3 entries keeps occupancy at 3
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 8'(8'hC3 + i), 1);
      checkOutput("simul", 8'(8'hC0 + i), 0, 0);
`ifdef SYN_FIFO_STATUS_EN
      checkVal("simul_count", 32'(fifo_count), 3);
`endif
    end
    // Top up to full, then both requests: only the read is taken
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 8'(8'hD0 + i), 0);
    checkVal("simul_full", 32'(bus.fifo_full), 1);
    applyStimulus(1, 1, 8'hEE, 1);
    checkOutput("full_both", 8'hC4, 0, 0);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("full_both_count", 32'(fifo_count), 7);
`endif
    applyStimulus(1, 0, 8'h00, 1);
    checkVal("full_both_rd1", 32'(bus.rd_data), 32'hC5);
    applyStimulus(1, 0, 8'h00, 1);
    checkVal("full_both_rd2", 32'(bus.rd_data), 32'hC6);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 8'h00, 1);
      checkOutput("full_both_tail", 8'(8'hD0 + i), 0, (i == 4) ? 1'b1 : 1'b0);
    end

    // Mid-operation reset discards stored entries; requests during reset are ignored
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 8'(i + 1), 0);
    applyStimulus(0, 1, 8'h99, 1);
    checkOutput("mid_reset", 8'h00, 0, 1);
`ifdef SYN_FIFO_STATUS_EN
    checkVal("mid_reset_count", 32'(fifo_count), 0);
`endif
    applyStimulus(1, 1, 8'h5A, 0);
    checkVal("post_reset_wr", 32'(bus.fifo_empty), 0);
    applyStimulus(1, 0, 8'h00, 1);
    checkOutput("post_reset_rd", 8'h5A, 0, 1);

    applyStimulus(1, 0, 8'h00, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
SYN_FIFO -- requirements
Module: syn_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of wr_data and rd_data in bits.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, minimum 2; ADDR_W = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 wr_en  input  1  write request.
REQ-006 wr_data  input  DATA_WIDTH  write data, sampled with wr_en.
REQ-007 rd_en  input  1  read request.
REQ-008 rd_data  output  DATA_WIDTH  registered read data.
REQ-009 fifo_full  output  1  high when DEPTH entries are stored.
REQ-010 fifo_empty  output  1  high when 0 entries are stored.

Function
REQ-011 Storage SHALL be a DEPTH x DATA_WIDTH register array, indexed by write and read pointers of ADDR_W+1 bits (extra wrap bit).
REQ-012 Write accepted iff wr_en=1 and fifo_full=0: mem[wptr] <= wr_data and wptr increments, on the same edge.
REQ-013 Read accepted iff rd_en=1 and fifo_empty=0: rd_data <= mem[rptr] and rptr increments; read latency is one clock (data valid after the accepting edge).
REQ-014 When no read is accepted, rd_data SHALL hold its last value.
REQ-015 Write while full is ignored: no pointer or memory change. Read while empty is ignored: rd_data and rptr unchanged.
REQ-016 Simultaneous accepted read and write (neither flag blocking) SHALL both occur; occupancy unchanged.
REQ-017 When full, wr_en+rd_en together: only the read is accepted. When empty, wr_en+rd_en together: only the write is accepted; the read is not bypassed.
REQ-018 fifo_empty = (wptr == rptr); fifo_full = (address bits equal AND wrap bits differ); both combinational from the pointer registers, so they reflect the edge's update in the same cycle.
REQ-019 Pointers wrap modulo 2*DEPTH; data order SHALL be strict first-in first-out across wrap-around.

Reset
REQ-020 While rstn=0 at a rising edge: wptr=0, rptr=0, rd_data=0, fifo_empty=1, fifo_full=0; wr_en and rd_en are ignored.
REQ-021 Memory contents are not cleared by reset.
REQ-022 Reset asserted mid-operation SHALL discard all stored entries; the first write after release is the first read.

Configuration
REQ-023 Macro SYN_FIFO_STATUS_EN: when defined, adds outputs fifo_count (ADDR_W+1 bits, wptr-rptr, 0..DEPTH), overflow (1 bit) and underflow (1 bit).
REQ-024 overflow SHALL pulse high for one cycle after an edge with wr_en=1 while full; underflow SHALL pulse high for one cycle after an edge with rd_en=1 while empty. All three outputs reset to 0.
REQ-025 When SYN_FIFO_STATUS_EN is not defined these ports and their logic SHALL be absent; the REQ-001..022 behaviour is identical in both builds.

Verification
REQ-026 Reset: rstn=0 for 1 edge -> fifo_empty=1, fifo_full=0, rd_data=0x00; reads issued while empty leave rd_data=0x00.
REQ-027 Basic order: write 0x11, 0x22, 0x33 on consecutive edges, then rd_en for 4 edges -> rd_data 0x11, 0x22, 0x33 on successive edges, then holds 0x33; fifo_empty=1 after the third read.
REQ-028 Full: write 0x00..0x07 (DEPTH=8) -> fifo_full=1 after 8th edge; 9th write 0xFF ignored; 8 reads return 0x00..0x07 and no 0xFF; overflow pulses once (status build).
REQ-029 Wrap: write 5, read 5, write 6, read 6 -> data in order, flags correct across pointer wrap; fifo_count tracks 0..6.
REQ-030 Simultaneous: with 3 entries, wr_en=rd_en=1 for 4 edges -> occupancy stays 3, data order preserved; when full, both asserted -> only read accepted, count 8->7.
REQ-031 Mid-operation reset: 4 entries stored, rstn=0 one edge -> fifo_empty=1; write 0x5A then read -> rd_data=0x5A.
